// File: rtl/mux_pkg.sv
// Shared types and constants for the N-channel scanning mux.
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MAN_HOLD = 2'd1,
    SCAN     = 2'd2,
    FIN      = 2'd3
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage : mux_pkg

// File: rtl/mux_nch_scan_next_en_find.sv
// Combinational search for the next enabled channel in a scan mask.
// With first=1 the lowest set bit is returned; otherwise the lowest set
// bit strictly above idx. found=0 when no such bit exists.
module next_en_find #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned SEL_W = 3
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] idx,
  input  logic             first,
  output logic             found,
  output logic [SEL_W-1:0] next_idx
);

  // Ascending priority scan; the first qualifying bit wins.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!found && mask[i] && (first || (i > 32'(idx)))) begin
        found    = 1'b1;
        next_idx = SEL_W'(i);
      end
    end
  end

endmodule : next_en_find

// File: rtl/mux_nch_scan.sv
// N_CH x W-bit channel mux with registered output, supporting a one-shot
// manual selection and an ascending auto-scan over an enable mask, both
// presented on a valid/ready output handshake.
module mux_nch_scan
  import mux_pkg::*;
#(
  parameter  int unsigned N_CH  = 8,
  parameter  int unsigned W     = 8,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [SEL_W-1:0]  sel,
  input  logic              mode,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              req,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              sel_err
);

  state_t            state_q, state_d;
  logic [W-1:0]      out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sel_err_q, sel_err_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [N_CH-1:0]   mask_q, mask_d;

  logic [N_CH-1:0]   find_mask;
  logic              find_first;
  logic              found;
  logic [SEL_W-1:0]  next_idx;
  logic [SEL_W-1:0]  src_idx;
  logic [W-1:0]      src_data;
  logic              handshake;

  assign handshake = out_valid_q & out_ready;

  // At scan start the live ch_en is searched; afterwards only the latched mask.
  always_comb begin
    find_mask  = mask_q;
    find_first = 1'b0;
    if (state_q == IDLE) begin
      find_mask  = ch_en;
      find_first = 1'b1;
    end
  end

  next_en_find #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_find (
    .mask     (find_mask),
    .idx      (idx_q),
    .first    (find_first),
    .found    (found),
    .next_idx (next_idx)
  );

  // Channel slice mux: manual select in IDLE, otherwise the next scan index.
  always_comb begin
    src_idx  = next_idx;
    src_data = '0;
    if (state_q == IDLE && mode == MODE_MANUAL) begin
      src_idx = sel;
    end
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (32'(src_idx) == i) begin
        src_data = in_data[i*W +: W];
      end
    end
  end

  // Next-state and next-output logic; registers hold unless a transition fires.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sel_err_d   = 1'b0;
    idx_d       = idx_q;
    mask_d      = mask_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (mode == MODE_MANUAL) begin
            if (32'(sel) < N_CH) begin
              out_data_d  = src_data;
              out_ch_d    = sel;
              out_valid_d = 1'b1;
              busy_d      = 1'b1;
              state_d     = MAN_HOLD;
            end else begin
              out_data_d = '0;
              out_ch_d   = sel;
              sel_err_d  = 1'b1;
            end
          end else begin
            mask_d = ch_en;
            if (found) begin
              out_data_d  = src_data;
              out_ch_d    = next_idx;
              idx_d       = next_idx;
              out_valid_d = 1'b1;
              busy_d      = 1'b1;
              state_d     = SCAN;
            end else begin
              // Empty mask: nothing to present, report completion directly.
              done_d  = 1'b1;
              state_d = FIN;
            end
          end
        end
      end

      MAN_HOLD: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      SCAN: begin
        if (handshake) begin
          if (found) begin
            // Load the following word on the same edge so words stream at full rate.
            out_data_d = src_data;
            out_ch_d   = next_idx;
            idx_d      = next_idx;
          end else begin
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = FIN;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sel_err_q   <= 1'b0;
      idx_q       <= '0;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sel_err_q   <= sel_err_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sel_err   = sel_err_q;

endmodule : mux_nch_scan

// File: tb/tb_mux_nch_scan.sv
// Directed self-checking bench for mux_nch_scan: an 8-channel instance for
// the main behaviour and a 6-channel instance for out-of-range selects.
module tb_mux_nch_scan;

  logic        clk;
  logic        rst;
  logic [63:0] in_data;
  logic [2:0]  sel;
  logic        mode;
  logic [7:0]  ch_en;
  logic        req;
  logic        req6;
  logic        out_ready;

  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic        sel_err;

  logic [7:0]  out_data6;
  logic [2:0]  out_ch6;
  logic        out_valid6;
  logic        busy6;
  logic        done6;
  logic        sel_err6;

  int unsigned tests;
  int unsigned fails;

  mux_nch_scan #(.N_CH(8), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .sel       (sel),
    .mode      (mode),
    .ch_en     (ch_en),
    .req       (req),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .sel_err   (sel_err)
  );

  mux_nch_scan #(.N_CH(6), .W(8)) dut6 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data[47:0]),
    .sel       (sel),
    .mode      (mode),
    .ch_en     (ch_en[5:0]),
    .req       (req6),
    .out_data  (out_data6),
    .out_ch    (out_ch6),
    .out_valid (out_valid6),
    .out_ready (out_ready),
    .busy      (busy6),
    .done      (done6),
    .sel_err   (sel_err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    sel       = '0;
    mode      = 1'b0;
    ch_en     = '0;
    req       = 1'b0;
    req6      = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(8'hA0 + i);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data,  0);
    chk("rst_ch",    out_ch,    0);
    chk("rst_busy",  busy,      0);
    chk("rst_done",  done,      0);
    chk("rst_err",   sel_err,   0);

    // 1. Manual select of channel 5 with consumer ready
    sel = 3'd5; mode = 1'b0; out_ready = 1'b1; req = 1'b1;
    tick();
    req = 1'b0;
    chk("man_valid", out_valid, 1);
    chk("man_data",  out_data,  8'hA5);
    chk("man_ch",    out_ch,    5);
    chk("man_busy",  busy,      1);
    tick();
    chk("man_hs_valid", out_valid, 0);
    chk("man_hs_busy",  busy,      0);

    // 2. Backpressure on channel 2; live data change and busy req are ignored
    sel = 3'd2; out_ready = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    chk("bp_data0",  out_data,  8'hA2);
    chk("bp_valid0", out_valid, 1);
    in_data[2*8 +: 8] = 8'h55;
    sel = 3'd6; req = 1'b1;
    tick();
    req = 1'b0;
    chk("bp_data1",  out_data,  8'hA2);
    chk("bp_ch1",    out_ch,    2);
    chk("bp_valid1", out_valid, 1);
    tick();
    tick();
    chk("bp_data3",  out_data,  8'hA2);
    chk("bp_valid3", out_valid, 1);
    chk("bp_busy3",  busy,      1);
    out_ready = 1'b1;
    tick();
    chk("bp_hs_valid", out_valid, 0);
    chk("bp_hs_busy",  busy,      0);
    out_ready = 1'b0;
    tick();
    chk("bp_single", out_valid, 0);
    in_data[2*8 +: 8] = 8'hA2;

    // 3. Scan over mask 1010_0110 at full rate
    ch_en = 8'b1010_0110; mode = 1'b1; out_ready = 1'b1; req = 1'b1;
    tick();
    req = 1'b0;
    ch_en = 8'hFF;
    chk("scan_ch0",   out_ch,    1);
    chk("scan_d0",    out_data,  8'hA1);
    chk("scan_v0",    out_valid, 1);
    chk("scan_busy0", busy,      1);
    tick();
    chk("scan_ch1", out_ch,   2);
    chk("scan_d1",  out_data, 8'hA2);
    mode = 1'b0; sel = 3'd0; req = 1'b1;
    tick();
    req = 1'b0; mode = 1'b1;
    chk("scan_ch2", out_ch,    5);
    chk("scan_d2",  out_data,  8'hA5);
    chk("scan_v2",  out_valid, 1);
    tick();
    chk("scan_ch3", out_ch,   7);
    chk("scan_d3",  out_data, 8'hA7);
    tick();
    chk("scan_end_valid", out_valid, 0);
    chk("scan_end_done",  done,      1);
    chk("scan_end_busy",  busy,      0);
    tick();
    chk("scan_done_clr", done, 0);

    // 4. Empty mask: done one cycle after req, no output; req in FIN ignored
    ch_en = 8'h00; mode = 1'b1; req = 1'b1;
    tick();
    chk("empty_valid", out_valid, 0);
    chk("empty_done",  done,      1);
    chk("empty_busy",  busy,      0);
    mode = 1'b0; sel = 3'd3;
    tick();
    req = 1'b0;
    chk("fin_req_valid", out_valid, 0);
    chk("fin_done_clr",  done,      0);

    // 5a. Out-of-range select on the 6-channel build
    sel = 3'd7; mode = 1'b0; req6 = 1'b1;
    tick();
    req6 = 1'b0;
    chk("err6_pulse", sel_err6,   1);
    chk("err6_data",  out_data6,  0);
    chk("err6_valid", out_valid6, 0);
    chk("err6_ch",    out_ch6,    7);
    tick();
    chk("err6_clr", sel_err6, 0);
    sel = 3'd4; req6 = 1'b1;
    tick();
    req6 = 1'b0;
    chk("ok6_data",  out_data6,  8'hA4);
    chk("ok6_valid", out_valid6, 1);
    chk("ok6_err",   sel_err6,   0);
    tick();

    // 5b. Reset at the second word of a scan
    ch_en = 8'b1010_0110; mode = 1'b1; out_ready = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("rs_ch_pre", out_ch, 2);
    out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_valid", out_valid, 0);
    chk("rs_data",  out_data,  0);
    chk("rs_ch",    out_ch,    0);
    chk("rs_busy",  busy,      0);
    chk("rs_done",  done,      0);
    tick();
    chk("rs_idle_valid", out_valid, 0);
    mode = 1'b0; sel = 3'd3; req = 1'b1;
    tick();
    req = 1'b0;
    chk("rs_man_data",  out_data,  8'hA3);
    chk("rs_man_valid", out_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mux_nch_scan

// File: doc/mux_nch_scan.md
Name: mux_nch_scan

Overview:
- Parametrised successor to the team's fixed 8:1 single-bit mux: N_CH channels, each W bits wide, with a registered output.
- Two modes:
  - Manual: one registered selection per request.
  - Auto-scan: steps through an enable mask of channels, presenting each on a valid/ready output handshake.
- Sits between a bank of parallel sources (sensor/status registers) and a single serial consumer.

Parameters:
- N_CH, 8, number of input channels (>=2; need not be a power of 2).
- W, 8, data width per channel.
- SEL_W, $clog2(N_CH), select/index width. Derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N_CH*W  packed channels; channel i = in_data[i*W +: W].
- sel  in  SEL_W  manual channel select.
- mode  in  1  0 = manual, 1 = auto-scan; sampled only when req is accepted.
- ch_en  in  N_CH  scan enable mask; sampled when a scan starts.
- req  in  1  single-cycle start pulse; ignored while busy=1.
- out_data  out  W  registered selected data.
- out_ch  out  SEL_W  index of the channel in out_data.
- out_valid  out  1  out_data/out_ch are valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- busy  out  1  high from accepted req until the final handshake completes.
- done  out  1  one-cycle pulse after a completed scan.
- sel_err  out  1  one-cycle pulse: manual sel >= N_CH.

Behaviour:
- Reset (sync, rst=1 at a clk edge): state IDLE; out_data=0, out_ch=0, out_valid=0, busy=0, done=0, sel_err=0; scan index and latched mask cleared. Reset wins over every other input, including mid-scan; any in-flight word is dropped.
- States: IDLE, MAN_HOLD, SCAN, FIN.
- IDLE with req=1, mode=0:
  - Next edge: out_data = channel[sel], out_ch = sel, out_valid=1, busy=1, go to MAN_HOLD.
  - Latency 1 cycle. Data is sampled at the req edge, not tracked live.
- IDLE with req=1, mode=0, sel >= N_CH:
  - out_data=0, out_ch=sel, sel_err pulses, out_valid=0, stay IDLE.
- MAN_HOLD: out_data/out_ch held stable while out_valid & !out_ready. On handshake: out_valid=0, busy=0, go to IDLE.
- IDLE with req=1, mode=1:
  - Latch ch_en to mask_q.
  - If mask_q==0: go to FIN with no valid output.
  - Else: load the lowest enabled channel (out_valid=1, busy=1) and go to SCAN.
- SCAN:
  - Handshake and a higher enabled channel exists: load that channel on the same edge (no bubble; back-to-back words at full rate).
  - Handshake on the last enabled channel: out_valid=0, go to FIN.
  - No handshake: hold everything.
- FIN: done=1 for exactly one cycle, busy=0, go to IDLE. A req arriving in FIN is ignored.
- Any req while busy=1 is ignored, with no side effects.
- Changes to ch_en during a scan are ignored; changes to in_data affect only channels not yet loaded.
- Channel order is strictly ascending; no wrap-around within one scan.
- out_valid never drops without a handshake except on reset.

Decomposition:
- Shared package mux_pkg:
  - state enum (IDLE, MAN_HOLD, SCAN, FIN);
  - MODE_MANUAL=1'b0, MODE_SCAN=1'b1.
- One sub-module, next_en_find (combinational). Inputs: mask, current index, first flag. Outputs: found, next_idx. Finds the lowest set bit strictly above the index, or at/above 0 when first.
- Top module holds the FSM, output registers and the channel slice mux.

Test Plan:
(N_CH=8, W=8, channel i = 8'hA0+i)
1. Manual: req, mode=0, sel=5, out_ready=1 -> next cycle out_valid=1, out_data=A5, out_ch=5; following cycle out_valid=0, busy=0.
2. Backpressure: manual sel=2, out_ready=0 for 4 cycles -> out_data=A2 held, out_valid=1 throughout. Change channel 2 to 8'h55 mid-hold -> out_data stays A2. Raise out_ready -> single handshake.
3. Scan: ch_en=8'b1010_0110, out_ready=1 -> out_ch 1,2,5,7 on consecutive cycles with data A1,A2,A5,A7; then done pulse; busy low.
4. Empty mask: ch_en=0, mode=1, req -> no out_valid; done pulses 1 cycle later.
5. Invalid select: N_CH=6 build, sel=7, mode=0 -> sel_err pulse, out_data=0, out_valid=0. Reset mid-scan at the 2nd word -> all outputs 0 the next cycle, state IDLE. A req pulsed during busy -> no effect.
